// File: rtl/lamp_fpu_sqrt_ctrl.sv
// lamp_fpu_sqrt_ctrl
// Initiator-side controller for the iterative fraction sqrt / inverse-sqrt
// core. A bfloat16 operand is unpacked and special operands are answered
// locally. Otherwise a 9-bit fraction is handed to the core with a one-cycle
// request. The Q2.16 answer is normalised, rounded to nearest-even and
// repacked as bfloat16 with sign 0.

module lamp_fpu_sqrt_ctrl #(
    parameter int LAMP_FLOAT_E_DW = 8,
    parameter int LAMP_FLOAT_F_DW = 7,
    parameter int LAMP_FLOAT_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        inv_i,
    input  logic [15:0] op_i,
    output logic        busy_o,
    output logic        doSqrt_o,
    output logic        doInvSqrt_o,
    output logic [8:0]  f_o,
    input  logic [17:0] result_i,
    input  logic        valid_i,
    output logic [15:0] result_o,
    output logic        valid_o,
    output logic        invalid_o,
    output logic        divzero_o
);

    localparam int DW = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RND   = 2'd3;

    localparam logic [8:0]  BIAS9   = 9'(LAMP_FLOAT_BIAS);
    localparam logic [7:0]  BIAS8   = 8'(LAMP_FLOAT_BIAS);
    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [14:0] INF_MAG = 15'h7F80;

    // Normalise a Q2.16 core result, round to nearest-even and pack a
    // positive bfloat16. exp_in is the biased exponent before normalisation.
    // Only the 16 bits that survive the shift are kept; bit 0 is lost on the
    // defensive right shift.
    function automatic logic [15:0] norm_round(input logic [17:0] r,
                                               input logic [7:0]  exp_in);
        logic [15:0] n;
        logic [7:0]  e;
        logic [6:0]  mant;
        logic        rnd_up;
        if (r[17]) begin
            n = r[16:1];
            e = exp_in + 8'd1;
        end else if (r[16]) begin
            n = r[15:0];
            e = exp_in;
        end else if (r[15]) begin
            n = {r[14:0], 1'b0};
            e = exp_in - 8'd1;
        end else begin
            n = {r[13:0], 2'b00};
            e = exp_in - 8'd2;
        end
        mant   = n[15:9];
        rnd_up = n[8] & ((|n[7:0]) | n[9]);
        if (rnd_up) begin
            if (mant == 7'h7F) begin
                mant = 7'h00;
                e    = e + 8'd1;
            end else begin
                mant = mant + 7'd1;
            end
        end else begin
            mant = n[15:9];
        end
        return {1'b0, e, mant};
    endfunction

    logic [1:0]  state_q,    state_d;
    logic [15:0] op_q,       op_d;
    logic        inv_q,      inv_d;
    logic [17:0] res_q,      res_d;
    logic [7:0]  exp_q,      exp_d;
    logic        busy_q,     busy_d;
    logic        do_sqrt_q,  do_sqrt_d;
    logic        do_inv_q,   do_inv_d;
    logic [8:0]  f_q,        f_d;
    logic [15:0] result_q,   result_d;
    logic        valid_q,    valid_d;
    logic        invalid_q,  invalid_d;
    logic        divzero_q,  divzero_d;

    logic                       op_sign;
    logic [LAMP_FLOAT_E_DW-1:0] op_exp;
    logic [LAMP_FLOAT_F_DW-1:0] op_man;
    logic [8:0]                 unb_exp;
    logic [7:0]                 half_exp;
    logic                       exp_max;
    logic                       exp_zero;
    logic                       man_zero;

    // Operand field extraction and classification of the latched operand
    always_comb begin
        op_sign  = op_q[DW-1];
        op_exp   = op_q[DW-2:LAMP_FLOAT_F_DW];
        op_man   = op_q[LAMP_FLOAT_F_DW-1:0];
        // Unbiased exponent E as a 9-bit two's complement value. Its
        // arithmetic shift right (bits [8:1]) floors E/2, which equals E'/2
        // for both parities, and bit 0 tells whether E is odd.
        unb_exp  = {1'b0, op_exp} - BIAS9;
        half_exp = unb_exp[8:1];
        exp_max  = (op_exp == {LAMP_FLOAT_E_DW{1'b1}});
        exp_zero = (op_exp == {LAMP_FLOAT_E_DW{1'b0}});
        man_zero = (op_man == {LAMP_FLOAT_F_DW{1'b0}});
    end

    // Next-state and registered-output computation for the controller FSM
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        inv_d     = inv_q;
        res_d     = res_q;
        exp_d     = exp_q;
        do_sqrt_d = 1'b0;
        do_inv_d  = 1'b0;
        f_d       = f_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        invalid_d = 1'b0;
        divzero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    inv_d   = inv_i;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (exp_max && !man_zero) begin
                    // NaN in, quiet NaN out, no flag
                    result_d = QNAN;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (op_sign && !exp_zero) begin
                    // Negative nonzero, including -inf (denormals count as 0)
                    result_d  = QNAN;
                    invalid_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (exp_zero) begin
                    // Zero or flushed denormal keeps its sign
                    if (inv_q) begin
                        result_d  = {op_sign, INF_MAG};
                        divzero_d = 1'b1;
                    end else begin
                        result_d  = {op_sign, 15'h0000};
                    end
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (exp_max) begin
                    // Only +inf reaches here
                    if (inv_q) begin
                        result_d = 16'h0000;
                    end else begin
                        result_d = {1'b0, INF_MAG};
                    end
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Even E: 1.m ; odd E: 2*1.m so that E' stays even
                    if (unb_exp[0]) begin
                        f_d = {1'b1, op_man, 1'b0};
                    end else begin
                        f_d = {2'b01, op_man};
                    end
                    if (inv_q) begin
                        exp_d    = BIAS8 - half_exp;
                        do_inv_d = 1'b1;
                    end else begin
                        exp_d     = BIAS8 + half_exp;
                        do_sqrt_d = 1'b1;
                    end
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (valid_i) begin
                    res_d   = result_i;
                    state_d = ST_RND;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RND: begin
                result_d = norm_round(res_q, exp_q);
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= 16'h0000;
            inv_q     <= 1'b0;
            res_q     <= 18'h00000;
            exp_q     <= 8'h00;
            busy_q    <= 1'b0;
            do_sqrt_q <= 1'b0;
            do_inv_q  <= 1'b0;
            f_q       <= 9'h000;
            result_q  <= 16'h0000;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            inv_q     <= inv_d;
            res_q     <= res_d;
            exp_q     <= exp_d;
            busy_q    <= busy_d;
            do_sqrt_q <= do_sqrt_d;
            do_inv_q  <= do_inv_d;
            f_q       <= f_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
            divzero_q <= divzero_d;
        end
    end

    assign busy_o      = busy_q;
    assign doSqrt_o    = do_sqrt_q;
    assign doInvSqrt_o = do_inv_q;
    assign f_o         = f_q;
    assign result_o    = result_q;
    assign valid_o     = valid_q;
    assign invalid_o   = invalid_q;
    assign divzero_o   = divzero_q;

endmodule

// File: doc/lamp_fpu_sqrt_ctrl.md
Name: lamp_fpu_sqrt_ctrl

Overview:
Initiator-side controller for the iterative fraction square-root / inverse-square-root core. It accepts a bfloat16 operand and unpacks it. It resolves special cases locally, or else prepares the 9-bit fraction, issues a one-cycle request to the core and waits for the core's valid. It then normalises and rounds the 18-bit core result, rebuilds sign and exponent, and returns the bfloat16 result with exception flags.

Parameters:
LAMP_FLOAT_E_DW, 8, exponent width
LAMP_FLOAT_F_DW, 7, stored mantissa width
LAMP_FLOAT_BIAS, 127, exponent bias

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  operation request, sampled only in IDLE
inv_i  in  1  0 = sqrt, 1 = inverse sqrt; sampled with start_i
op_i  in  16  bfloat16 operand {s[15], e[14:7], m[6:0]}
busy_o  out  1  high in every state except IDLE
doSqrt_o  out  1  one-cycle request to core, sqrt
doInvSqrt_o  out  1  one-cycle request to core, inverse sqrt
f_o  out  9  core fraction, valid while doSqrt_o or doInvSqrt_o is high
result_i  in  18  core result, unsigned Q2.16
valid_i  in  1  core result valid, one-cycle pulse
result_o  out  16  bfloat16 result
valid_o  out  1  one-cycle result strobe
invalid_o  out  1  invalid-operation flag, qualified by valid_o
divzero_o  out  1  divide-by-zero flag, qualified by valid_o

Behaviour:
- All outputs are registered. Reset value of every output and every state register is 0, and the FSM resets to IDLE.
- Reset asserted in any state aborts the operation. No valid_o is produced. The core shares rst and aborts at the same time.
- FSM states: IDLE, CHECK, WAIT, RND.
- IDLE: when start_i is high in cycle T, register op_i and inv_i, then go to CHECK. When start_i is low, stay in IDLE.
- CHECK (cycle T+1): classify the operand and take one of two paths.
- Special path: load result_o and the flags, set valid_o high in T+2, return to IDLE.
- Normal path: set exactly one of doSqrt_o/doInvSqrt_o, matching inv, high for cycle T+2 only, drive f_o, go to WAIT.
- Denormals (e=0, m≠0) are flushed to zero and keep their sign.
- Special results, in priority order:
  - NaN operand: result 0x7FC0, no flag.
  - Negative nonzero operand, including -inf: result 0x7FC0, invalid_o=1.
  - ±0, sqrt: result ±0.
  - ±0, inverse sqrt: result ±inf (0x7F80/0xFF80), divzero_o=1.
  - +inf, sqrt: result +inf.
  - +inf, inverse sqrt: result +0.
- Fraction preparation: E = e − bias.
  - E even: f_o = {2'b01, m}, meaning 1.m. Use E' = E.
  - E odd: f_o = {1'b1, m, 1'b0}, meaning 2·1.m. Use E' = E − 1.
  - E' is always even. Halving is an arithmetic shift of a signed 9-bit value.
- WAIT: stay until valid_i is sampled high in cycle W. Capture result_i, go to RND.
- valid_i outside WAIT is ignored.
- start_i while busy_o is high is ignored. It is not queued.
- RND (cycle W+1): produce valid_o and result_o in W+2, then return to IDLE.
- Result exponent before normalisation:
  - sqrt: bias + E'/2.
  - inverse sqrt: bias − E'/2.
- Normalisation:
  - If r[17]=1 (defensive): shift right 1, exponent +1.
  - Else if r[16]=1: no shift.
  - Else if r[15]=1: shift left 1, exponent −1.
  - Else (r[17:15]=0): shift left 2, exponent −2.
- After normalisation: mantissa = bits[15:9], guard = bit8, sticky = OR of bits[7:0].
- Rounding is round-to-nearest-even. A mantissa carry-out sets mantissa 0 and adds 1 to the exponent.
- Sign of every normal-path result is 0. No overflow or underflow is reachable for a bfloat16 input.

Test Plan:
1. sqrt(4.0): op_i=0x4080, inv=0 → f_o=0x080, one-cycle doSqrt_o; core returns 0x10000 → result_o=0x4000, flags 0, valid_o exactly 2 cycles after valid_i.
2. sqrt(2.0): op_i=0x4000 → f_o=0x100; core returns 0x16A0A → result_o=0x3FB5.
3. Inverse sqrt(4.0): op_i=0x4080, inv=1 → f_o=0x080, doInvSqrt_o pulse; core returns 0x10000 → result_o=0x3F00.
4. Specials, each with no core request and valid_o at T+2:
   - 0xBF80 sqrt → 0x7FC0, invalid_o=1.
   - 0x0000 inverse sqrt → 0x7F80, divzero_o=1.
   - 0x8000 sqrt → 0x8000.
   - 0x7F80 inverse sqrt → 0x0000.
   - 0x7FC1 → 0x7FC0, no flag.
5. Rounding: core returns 0x16B00 (guard=1, sticky=0, lsb=1) with exponent bias → mantissa rounds up to 0x36. A case with m=0x7F and guard=1 carries, mantissa becomes 0 and exponent increments.
6. Busy and reset:
   - start_i pulsed during WAIT is ignored: single valid_o, and the result matches the first operand.
   - rst asserted during WAIT → all outputs 0 next cycle, IDLE, no valid_o.
   - A later valid_i while in IDLE is ignored.
